// File: rtl/if_fetch_pkg.sv
// Shared constants, FSM encoding and fetch-queue entry layout for the
// instruction-fetch stage.
package if_fetch_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] NOP     = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] ZERO    = '0;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] inst;
  } fq_entry_t;

  localparam int FQ_ENTRY_W = $bits(fq_entry_t);

  function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] pc);
    return {pc[ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Small synchronous FIFO with clear; used for both the in-flight address
// FIFO and the fetch queue. DEPTH must be a power of two.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    // NOTE: every comb-assigned signal gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests and
// buffers returned words for decode; redirects flush and discard stale data.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000,
  parameter int                    FQ_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  output logic                  inst_valid_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  output logic [DATA_WIDTH-1:0] inst_o
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  if_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         stale_q, stale_d;

  logic                  grant;
  logic                  rv_keep;
  logic                  credit_ok;

  logic [ADDR_WIDTH-1:0] af_rdata;
  logic                  af_full, af_empty;
  logic [CW-1:0]         af_count;

  fq_entry_t             fq_wdata, fq_head;
  logic [FQ_ENTRY_W-1:0] fq_rdata;
  logic                  fq_full, fq_empty, fq_pop;
  logic [CW-1:0]         fq_count;

  logic                  unused_fifo_flags;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (redirect_i && (stale_d != '0)) state_d = S_FLUSH;
      S_FLUSH: if (stale_d == '0) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // Queue slots plus in-flight requests never exceed FQ_DEPTH, so every
  // response that comes back is guaranteed a fetch-queue slot.
  assign credit_ok = (int'(outstanding_q) + int'(fq_count)) < FQ_DEPTH;

  always_comb begin
    imem_req_o = 1'b0;
    if (state_q == S_RUN) imem_req_o = credit_ok && !redirect_i;
  end

  assign imem_addr_o = pc_q;
  assign grant       = imem_req_o && imem_gnt_i;
  assign rv_keep     = imem_rvalid_i && (state_q == S_RUN) && !redirect_i;

  // ---------------------------------------------------------------------------
  // PC, outstanding and stale counters
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
    stale_d       = stale_q;

    if (redirect_i)  pc_d = align_pc(redirect_pc_i);
    else if (grant)  pc_d = pc_q + PC_STEP;

    if (state_q == S_FLUSH) begin
      // Further redirects here only move the PC; the countdown continues.
      if (imem_rvalid_i && (stale_q != '0)) stale_d = stale_q - CW'(1);
    end else if (redirect_i) begin
      stale_d = outstanding_q + CW'(grant) - CW'(imem_rvalid_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Address FIFO (PC of each granted request) and fetch queue
  // ---------------------------------------------------------------------------
  fetch_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (FQ_DEPTH)
  ) u_addr_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .wdata_i (pc_q),
    .pop_i   (rv_keep),
    .clear_i (redirect_i),
    .rdata_o (af_rdata),
    .full_o  (af_full),
    .empty_o (af_empty),
    .count_o (af_count)
  );

  assign fq_wdata.addr = af_rdata;
  assign fq_wdata.inst = imem_rdata_i;
  assign fq_pop        = inst_valid_o && !stall_i;

  fetch_fifo #(
    .WIDTH (FQ_ENTRY_W),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rv_keep),
    .wdata_i (fq_wdata),
    .pop_i   (fq_pop),
    .clear_i (redirect_i),
    .rdata_o (fq_rdata),
    .full_o  (fq_full),
    .empty_o (fq_empty),
    .count_o (fq_count)
  );

  assign fq_head      = fq_entry_t'(fq_rdata);
  assign inst_valid_o = !fq_empty;
  assign inst_addr_o  = inst_valid_o ? fq_head.addr : ZERO;
  assign inst_o       = inst_valid_o ? fq_head.inst : NOP;

  assign unused_fifo_flags = ^{af_full, af_empty, af_count, fq_full};

endmodule
